// File: rtl/sti_rx.sv
// sti_rx: STI serial-to-parallel receiver; rebuilds frames and recovers the 16-bit payload.
// Define STI_RX_ERR_EN to abort frames on mid-frame so_valid gaps and pulse rx_err.
module sti_rx (
  input  logic        clk,
  input  logic        reset,
  input  logic        so_data,
  input  logic        so_valid,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_fill,
  input  logic        cfg_msb,
  input  logic        rx_ready,
  output logic        rx_valid,
  output logic [15:0] rx_data,
  output logic [31:0] rx_frame,
  output logic        rx_overrun,
  output logic        rx_err
);
  typedef enum logic {IDLE, RECV} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d, n_bits;
  logic [31:0] sh_q, sh_d, frame_d;
  logic [1:0]  len_q, len_d;
  logic        fill_q, fill_d, msb_q, msb_d;
  logic        done, load;
  logic [15:0] payload;
  logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, rx_err_q, rx_err_d;
  logic [15:0] rx_data_q, rx_data_d;
  logic [31:0] rx_frame_q, rx_frame_d;
  assign n_bits = ({4'd0, len_q} + 6'd1) << 3;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    len_d    = len_q;
    fill_d   = fill_q;
    msb_d    = msb_q;
    done     = 1'b0;
    rx_err_d = 1'b0;
    if (state_q == IDLE) begin
      if (so_valid) begin
        state_d = RECV;
        cnt_d   = 6'd1;
        sh_d    = {31'd0, so_data};
        len_d   = cfg_length;
        fill_d  = cfg_fill;
        msb_d   = cfg_msb;
      end
    end else if (so_valid) begin
      sh_d = msb_q ? {sh_q[30:0], so_data} : sh_q;
      if (!msb_q) sh_d[cnt_q[4:0]] = so_data;
      cnt_d = cnt_q + 6'd1;
      done  = cnt_d == n_bits;
    end
`ifdef STI_RX_ERR_EN
    else begin
      rx_err_d = 1'b1;
      state_d  = IDLE;
      cnt_d    = 6'd0;
      sh_d     = 32'd0;
    end
`endif
    frame_d = sh_d;
    if (done) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
      sh_d    = 32'd0;
    end
    payload      = (fill_q && len_q[1]) ? (len_q[0] ? frame_d[31:16] : frame_d[23:8]) : frame_d[15:0];
    load         = done && (!rx_valid_q || rx_ready);
    rx_overrun_d = done && rx_valid_q && !rx_ready;
    rx_valid_d   = load || (rx_valid_q && !rx_ready);
    rx_data_d    = load ? payload : rx_data_q;
    rx_frame_d   = load ? frame_d : rx_frame_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 6'd0;
      sh_q         <= 32'd0;
      len_q        <= 2'd0;
      fill_q       <= 1'b0;
      msb_q        <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 16'd0;
      rx_frame_q   <= 32'd0;
      rx_overrun_q <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      len_q        <= len_d;
      fill_q       <= fill_d;
      msb_q        <= msb_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      rx_frame_q   <= rx_frame_d;
      rx_overrun_q <= rx_overrun_d;
      rx_err_q     <= rx_err_d;
    end
  end
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign rx_frame   = rx_frame_q;
  assign rx_overrun = rx_overrun_q;
  assign rx_err     = rx_err_q;
endmodule

// File: tb/tb_sti_rx.sv
// tb_sti_rx: directed vector table, corner sequences and random traffic against a queue-based model.
module tb_sti_rx;
  logic clk = 1'b0;
  logic reset, so_data, so_valid, rx_ready, cfg_fill, cfg_msb;
  logic [1:0]  cfg_length;
  logic        rx_valid, rx_overrun, rx_err;
  logic [15:0] rx_data;
  logic [31:0] rx_frame;
  int n_chk = 0, n_fail = 0;
`ifdef STI_RX_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  sti_rx dut (
    .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid),
    .cfg_length(cfg_length), .cfg_fill(cfg_fill), .cfg_msb(cfg_msb), .rx_ready(rx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_frame(rx_frame),
    .rx_overrun(rx_overrun), .rx_err(rx_err)
  );
  always #5 clk = ~clk;
  bit          mq[$];
  int          m_n;
  bit          m_fill, m_msb, m_valid, m_ov, m_err;
  logic [15:0] m_data;
  logic [31:0] m_frame;
  function automatic logic [15:0] payload(logic [31:0] f);
    if (m_fill && m_n == 24) return f[23:8];
    if (m_fill && m_n == 32) return f[31:16];
    return f[15:0];
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model(input bit v, input bit d, input bit rdy, input bit rst);
    bit done = 1'b0;
    logic [31:0] f = 32'd0;
    if (rst) begin
      mq.delete();
      {m_valid, m_ov, m_err, m_data, m_frame} = '0;
      return;
    end
    m_ov  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (mq.size() == 0) begin
        m_n    = 8 * (int'(cfg_length) + 1);
        m_fill = cfg_fill;
        m_msb  = cfg_msb;
      end
      mq.push_back(d);
      if (mq.size() == m_n) begin
        done = 1'b1;
        for (int i = 0; i < m_n; i++)
          f = m_msb ? (f << 1) | 32'(mq[i]) : f | (32'(mq[i]) << i);
        mq.delete();
      end
    end else if (ERR && mq.size() > 0) begin
      m_err = 1'b1;
      mq.delete();
    end
    if (done) begin
      if (m_valid && !rdy) m_ov = 1'b1;
      else begin
        m_valid = 1'b1;
        m_frame = f;
        m_data  = payload(f);
      end
    end else if (rdy) m_valid = 1'b0;
  endtask
  task automatic step(input bit v, input bit d, input bit rdy, input bit rst = 1'b0);
    so_valid = v;
    so_data  = d;
    rx_ready = rdy;
    reset    = rst;
    @(posedge clk);
    model(v, d, rdy, rst);
    #1;
    chk("outputs", 64'({rx_valid, rx_overrun, rx_err, rx_data, rx_frame}),
        64'({m_valid, m_ov, m_err, m_data, m_frame}));
  endtask
  task automatic send_frame(input logic [1:0] len, input bit fill, input bit msb,
                            input logic [31:0] fr, input bit rdy, input int nbits = 0);
    int n = 8 * (int'(len) + 1);
    int stop = (nbits == 0) ? n : nbits;
    cfg_length = len;
    cfg_fill   = fill;
    cfg_msb    = msb;
    for (int i = 0; i < stop; i++) step(1'b1, msb ? fr[n-1-i] : fr[i], rdy);
  endtask
  typedef struct {
    logic [1:0]  len;
    bit          fill;
    bit          msb;
    logic [31:0] frame;
    logic [15:0] data;
  } vec_t;
  vec_t tv[6];
  logic [15:0] gv;
  initial begin
    tv[0] = '{2'd1, 1'b0, 1'b1, 32'h0000A5C3, 16'hA5C3};
    tv[1] = '{2'd0, 1'b0, 1'b0, 32'h0000003C, 16'h003C};
    tv[2] = '{2'd2, 1'b1, 1'b1, 32'h00123400, 16'h1234};
    tv[3] = '{2'd3, 1'b0, 1'b1, 32'h0000BEEF, 16'hBEEF};
    tv[4] = '{2'd3, 1'b1, 1'b0, 32'hDEAD0000, 16'hDEAD};
    tv[5] = '{2'd2, 1'b0, 1'b0, 32'h0000ABCD, 16'hABCD};
    cfg_length = 2'd0;
    cfg_fill   = 1'b0;
    cfg_msb    = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_outs", 64'({rx_valid, rx_overrun, rx_err, rx_data, rx_frame}), 64'd0);
    for (int i = 0; i < 6; i++) begin
      send_frame(tv[i].len, tv[i].fill, tv[i].msb, tv[i].frame, 1'b1);
      chk("tbl_valid", 64'(rx_valid), 64'd1);
      chk("tbl_data", 64'(rx_data), 64'(tv[i].data));
      chk("tbl_frame", 64'(rx_frame), 64'(tv[i].frame));
      step(1'b0, 1'b0, 1'b1);
    end
    send_frame(2'd2, 1'b1, 1'b1, 32'h00123400, 1'b1);
    chk("b2b_first", 64'(rx_data), 64'h1234);
    send_frame(2'd3, 1'b0, 1'b1, 32'h0000BEEF, 1'b1);
    chk("b2b_second", 64'(rx_data), 64'hBEEF);
    chk("b2b_valid", 64'(rx_valid), 64'd1);
    step(1'b0, 1'b0, 1'b1);
    send_frame(2'd0, 1'b0, 1'b1, 32'h11, 1'b0);
    chk("ovr_first", 64'({rx_valid, rx_data}), 64'h1_0011);
    send_frame(2'd0, 1'b0, 1'b1, 32'h22, 1'b0);
    chk("ovr_pulse", 64'({rx_overrun, rx_valid, rx_data}), 64'h3_0011);
    step(1'b0, 1'b0, 1'b0);
    chk("ovr_once", 64'({rx_overrun, rx_valid}), 64'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("ovr_drain", 64'(rx_valid), 64'd0);
    gv = 16'h5AA5;
    cfg_length = 2'd1;
    cfg_msb    = 1'b1;
    cfg_fill   = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, gv[15-i], 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("gap_err", 64'(rx_err), 64'(ERR));
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 5; i < 16; i++) step(1'b1, gv[15-i], 1'b1);
    chk("gap_valid", 64'(rx_valid), 64'(!ERR));
    chk("gap_data", 64'(rx_data), ERR ? 64'h0011 : 64'h5AA5);
    step(1'b0, 1'b0, 1'b1);
    send_frame(2'd1, 1'b0, 1'b1, 32'h1234, 1'b1, 10);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_mid", 64'({rx_valid, rx_overrun, rx_err, rx_data, rx_frame}), 64'd0);
    send_frame(2'd1, 1'b0, 1'b1, 32'h0F0F, 1'b1);
    chk("rst_fresh", 64'({rx_valid, rx_data, rx_frame}), {15'd0, 1'b1, 16'h0F0F, 32'h00000F0F});
    step(1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 400; f++) begin
      int n;
      cfg_length = 2'($urandom_range(0, 3));
      cfg_fill   = 1'($urandom_range(0, 1));
      cfg_msb    = 1'($urandom_range(0, 1));
      n = 8 * (int'(cfg_length) + 1);
      for (int b = 0; b < n; b++) begin
        while ($urandom_range(0, 19) == 0) step(1'b0, 1'b0, $urandom_range(0, 3) != 0);
        step(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b0, 1'b0, $urandom_range(0, 3) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
